mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port res, input, 32 bits: ALU result from EX/MEM register; data address for loads/stores.
REQ-004 SHALL have port data_2, input, 32 bits: store data.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port write_register, input, 5 bits: destination register.
REQ-007 SHALL have port m_MEM, input, 3 bits: [2]=Branch, [1]=MemRead, [0]=MemWrite.
REQ-008 SHALL have port wb_MEM, input, 2 bits: [1]=RegWrite, [0]=MemtoReg.
REQ-009 SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, 32), dmem_wdata (output, 32), dmem_rdata (input, 32), dmem_ack (input, 1): data-memory handshake.
REQ-010 SHALL have port stall, output, 1 bit: upstream stages hold while high.
REQ-011 SHALL have port pc_src, output, 1 bit: branch taken.
REQ-012 SHALL have ports read_data_WB (32), alu_res_WB (32), write_register_WB (5), wb_WB (2), all outputs: MEM/WB register.
REQ-013 SHALL have port bus_err, output, 1 bit: one-cycle pulse on access timeout.
REQ-014 SHALL have parameter TIMEOUT, default 15: maximum BUSY cycles waiting for dmem_ack.

Function
REQ-015 SHALL define mem_op = m_MEM[1] | m_MEM[0]; if both bits set, treat as write.
REQ-016 SHALL implement FSM states IDLE and BUSY; IDLE->BUSY when mem_op & ~dmem_ack; BUSY->IDLE on dmem_ack or timeout.
REQ-017 SHALL drive dmem_req = mem_op in IDLE and 1 in BUSY, combinationally; dmem_addr = res, dmem_wdata = data_2, dmem_we = m_MEM[0]; stable while req high.
REQ-018 SHALL complete zero-wait when dmem_ack is high in the IDLE request cycle (no BUSY entry, no stall).
REQ-019 SHALL drive stall = dmem_req & ~dmem_ack, combinationally.
REQ-020 SHALL keep a 4-bit wait counter, cleared on BUSY entry, incremented each BUSY cycle without ack.
REQ-021 SHALL on counter == TIMEOUT without ack: pulse bus_err for one cycle, return to IDLE, deassert stall, load a bubble into MEM/WB.
REQ-022 SHALL on each rising edge with stall low load MEM/WB: alu_res_WB<=res, write_register_WB<=write_register, wb_WB<=wb_MEM, read_data_WB<=dmem_rdata if load acked else 0.
REQ-023 SHALL on each edge with stall high load a bubble: wb_WB<=0, other MEM/WB fields unchanged.
REQ-024 SHALL drive pc_src = m_MEM[2] & zero, combinationally, independent of stall.
REQ-025 SHALL ignore dmem_ack when dmem_req is low.

Reset
REQ-026 SHALL on rst: state IDLE, counter 0, bus_err 0, read_data_WB, alu_res_WB, write_register_WB, wb_WB all 0.
REQ-027 SHALL on rst asserted mid-BUSY drop dmem_req and stall immediately (asynchronously) and abandon the access.

Configuration
REQ-028 SHALL, with MEM_ALIGN_CHECK_EN defined, treat mem_op with res[1:0] != 0 as misaligned: no dmem_req issued, bus_err pulsed next edge, bubble loaded into MEM/WB.
REQ-029 SHALL, without MEM_ALIGN_CHECK_EN, issue all accesses regardless of res[1:0], with no alignment logic present.

Verification
REQ-030 SHALL cover zero-wait load: m_MEM=010, res=0x40, dmem_ack=1 same cycle, rdata=0xDEADBEEF -> stall never high, next edge read_data_WB=0xDEADBEEF, wb_WB=wb_MEM.
REQ-031 SHALL cover 3-wait store: m_MEM=001, data_2=0x12345678, ack on 4th request cycle -> dmem_we=1, stall high exactly 3 cycles, wb_WB=0 during those edges.
REQ-032 SHALL cover timeout: load with ack never asserted -> stall high 16 cycles, bus_err single pulse, then stall low and wb_WB=0.
REQ-033 SHALL cover branch: m_MEM=100, zero=1 -> pc_src=1 same cycle, no dmem_req; zero=0 -> pc_src=0.
REQ-034 SHALL cover reset mid-BUSY: rst asserted in 2nd wait cycle -> dmem_req and stall low immediately, all MEM/WB outputs 0.
REQ-035 SHALL cover, with MEM_ALIGN_CHECK_EN, load at res=0x42 -> dmem_req never high, bus_err pulses, wb_WB=0.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory req/ack handshake with wait/timeout FSM, branch resolve, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: misaligned word accesses are dropped and flagged on bus_err.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] res,
   input  logic [31:0] data_2,
   input  logic        zero,
   input  logic [4:0]  write_register,
   input  logic [2:0]  m_MEM,
   input  logic [1:0]  wb_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] read_data_WB,
   output logic [31:0] alu_res_WB,
   output logic [4:0]  write_register_WB,
   output logic [1:0]  wb_WB,
   output logic        bus_err,
   output logic        dbg_state
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   // Handshake: dmem_req is held with stable addr/we/wdata until a cycle in
   // which dmem_ack is high; that cycle completes the access. ack is ignored
   // whenever req is low.
   logic [0:0] state;
   logic [3:0] wait_cnt;
   logic       mem_op;
   logic       issue;
   logic       timeout_hit;
   logic       load_ack;
   logic       drop_op;

   assign mem_op = m_MEM[1] | m_MEM[0];

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = (state == IDLE) & mem_op & (res[1:0] != 2'b00);
   assign issue      = mem_op & ~misaligned;
   assign drop_op    = misaligned;
`else
   assign issue      = mem_op;
   assign drop_op    = 1'b0;
`endif

   assign timeout_hit = (state == BUSY) & (wait_cnt == TIMEOUT_CNT) & ~dmem_ack;

   // rst gates req directly so an in-flight access is abandoned at once.
   assign dmem_req   = ~rst & ((state == BUSY) | issue);
   assign dmem_we    = m_MEM[0];
   assign dmem_addr  = res;
   assign dmem_wdata = data_2;
   // The timeout cycle releases the pipeline; the instruction retires as a bubble.
   assign stall      = dmem_req & ~dmem_ack & ~timeout_hit;
   assign load_ack   = dmem_req & dmem_ack & m_MEM[1] & ~m_MEM[0];
   assign pc_src     = m_MEM[2] & zero;
   assign dbg_state  = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (issue & ~dmem_ack) begin
                  state    <= BUSY;
                  wait_cnt <= 4'd0;
               end
            end
            BUSY: begin
               if (dmem_ack | timeout_hit) state <= IDLE;
               else                        wait_cnt <= wait_cnt + 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data_WB      <= 32'd0;
         alu_res_WB        <= 32'd0;
         write_register_WB <= 5'd0;
         wb_WB             <= 2'b00;
         bus_err           <= 1'b0;
      end else begin
         bus_err <= timeout_hit | drop_op;
         if (stall | timeout_hit | drop_op) begin
            wb_WB <= 2'b00;
         end else begin
            alu_res_WB        <= res;
            write_register_WB <= write_register;
            wb_WB             <= wb_MEM;
            read_data_WB      <= load_ack ? dmem_rdata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, zero-wait load, wait-state store,
// timeout, branch, reset mid-access and the alignment option.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic [31:0] res;
   logic [31:0] data_2;
   logic        zero;
   logic [4:0]  write_register;
   logic [2:0]  m_MEM;
   logic [1:0]  wb_MEM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        pc_src;
   logic [31:0] read_data_WB;
   logic [31:0] alu_res_WB;
   logic [4:0]  write_register_WB;
   logic [1:0]  wb_WB;
   logic        bus_err;
   logic        dbg_state;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   mem_stage #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .res(res), .data_2(data_2), .zero(zero),
      .write_register(write_register), .m_MEM(m_MEM), .wb_MEM(wb_MEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .pc_src(pc_src), .read_data_WB(read_data_WB),
      .alu_res_WB(alu_res_WB), .write_register_WB(write_register_WB),
      .wb_WB(wb_WB), .bus_err(bus_err), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      m_MEM          = 3'b000;
      wb_MEM         = 2'b00;
      res            = 32'd0;
      data_2         = 32'd0;
      zero           = 1'b0;
      write_register = 5'd0;
      dmem_ack       = 1'b0;
      dmem_rdata     = 32'd0;
   endtask

   task automatic test_reset();
      drive_idle();
      m_MEM  = 3'b010;
      wb_MEM = 2'b11;
      rst    = 1'b1;
      #2;
      chk_cnt++; if (dmem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", dmem_req); else pass_cnt++;
      chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass_cnt++;
      chk_cnt++; if (read_data_WB !== 32'd0 || alu_res_WB !== 32'd0)
         $display("FAIL reset_data got %h/%h exp 0/0", read_data_WB, alu_res_WB); else pass_cnt++;
      chk_cnt++; if (write_register_WB !== 5'd0 || wb_WB !== 2'b00 || bus_err !== 1'b0)
         $display("FAIL reset_ctrl got %h/%b/%b exp 0/00/0", write_register_WB, wb_WB, bus_err); else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_zero_wait_load();
      m_MEM = 3'b010; res = 32'h40; wb_MEM = 2'b11; write_register = 5'd5;
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      chk_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40)
         $display("FAIL zw_req got req=%b we=%b addr=%h exp 1/0/40", dmem_req, dmem_we, dmem_addr); else pass_cnt++;
      chk_cnt++; if (stall !== 1'b0) $display("FAIL zw_stall got %b exp 0", stall); else pass_cnt++;
      tick();
      chk_cnt++; if (read_data_WB !== 32'hDEADBEEF) $display("FAIL zw_rdata got %h exp deadbeef", read_data_WB); else pass_cnt++;
      chk_cnt++; if (wb_WB !== 2'b11 || alu_res_WB !== 32'h40 || write_register_WB !== 5'd5)
         $display("FAIL zw_wb got %b/%h/%0d exp 11/40/5", wb_WB, alu_res_WB, write_register_WB); else pass_cnt++;
      // back-to-back second zero-wait load
      res = 32'h44; dmem_rdata = 32'h0BADF00D; wb_MEM = 2'b01; write_register = 5'd9;
      #1;
      chk_cnt++; if (stall !== 1'b0 || dmem_addr !== 32'h44)
         $display("FAIL b2b_req got stall=%b addr=%h exp 0/44", stall, dmem_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (read_data_WB !== 32'h0BADF00D || wb_WB !== 2'b01 || write_register_WB !== 5'd9)
         $display("FAIL b2b_wb got %h/%b/%0d exp 0badf00d/01/9", read_data_WB, wb_WB, write_register_WB); else pass_cnt++;
      drive_idle();
   endtask

   task automatic test_wait_store();
      int stalls = 0;
      m_MEM = 3'b001; res = 32'h80; data_2 = 32'h12345678; wb_MEM = 2'b10; write_register = 5'd3;
      for (int i = 0; i < 4; i++) begin
         dmem_ack = (i == 3);
         #1;
         chk_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h12345678)
            $display("FAIL st_req[%0d] got req=%b we=%b wdata=%h exp 1/1/12345678", i, dmem_req, dmem_we, dmem_wdata);
         else pass_cnt++;
         if (stall === 1'b1) stalls++;
         tick();
         if (i < 3) begin
            chk_cnt++; if (wb_WB !== 2'b00) $display("FAIL st_bubble[%0d] got %b exp 00", i, wb_WB); else pass_cnt++;
         end
      end
      chk_cnt++; if (stalls != 3) $display("FAIL st_stall_cnt got %0d exp 3", stalls); else pass_cnt++;
      chk_cnt++; if (wb_WB !== 2'b10 || alu_res_WB !== 32'h80 || read_data_WB !== 32'd0)
         $display("FAIL st_wb got %b/%h/%h exp 10/80/0", wb_WB, alu_res_WB, read_data_WB); else pass_cnt++;
      drive_idle();
   endtask

   task automatic test_timeout();
      int stalls = 0;
      int errs   = 0;
      m_MEM = 3'b010; res = 32'h100; wb_MEM = 2'b11; write_register = 5'd4;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (bus_err === 1'b1) errs++;
         if (stall !== 1'b1) break;
         stalls++;
         tick();
      end
      chk_cnt++; if (stalls != 16) $display("FAIL to_stall_cnt got %0d exp 16", stalls); else pass_cnt++;
      chk_cnt++; if (stall !== 1'b0 || errs != 0)
         $display("FAIL to_release got stall=%b early_err=%0d exp 0/0", stall, errs); else pass_cnt++;
      tick();
      drive_idle();
      chk_cnt++; if (bus_err !== 1'b1 || wb_WB !== 2'b00)
         $display("FAIL to_err got bus_err=%b wb=%b exp 1/00", bus_err, wb_WB); else pass_cnt++;
      tick();
      chk_cnt++; if (bus_err !== 1'b0 || stall !== 1'b0)
         $display("FAIL to_pulse got bus_err=%b stall=%b exp 0/0", bus_err, stall); else pass_cnt++;
   endtask

   task automatic test_branch();
      m_MEM = 3'b100; zero = 1'b1; res = 32'h300; wb_MEM = 2'b10; write_register = 5'd7;
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      #1;
      chk_cnt++; if (pc_src !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL br_taken got pc_src=%b req=%b stall=%b exp 1/0/0", pc_src, dmem_req, stall); else pass_cnt++;
      zero = 1'b0;
      #1;
      chk_cnt++; if (pc_src !== 1'b0) $display("FAIL br_not_taken got %b exp 0", pc_src); else pass_cnt++;
      tick();
      chk_cnt++; if (read_data_WB !== 32'd0 || wb_WB !== 2'b10 || alu_res_WB !== 32'h300)
         $display("FAIL br_wb got %h/%b/%h exp 0/10/300", read_data_WB, wb_WB, alu_res_WB); else pass_cnt++;
      drive_idle();
   endtask

   task automatic test_reset_mid_busy();
      m_MEM = 3'b010; res = 32'h200; wb_MEM = 2'b11; write_register = 5'd2;
      tick();
      tick();
      chk_cnt++; if (stall !== 1'b1 || dbg_state !== 1'b1)
         $display("FAIL rb_pre got stall=%b state=%b exp 1/1", stall, dbg_state); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      chk_cnt++; if (dmem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL rb_async got req=%b stall=%b exp 0/0", dmem_req, stall); else pass_cnt++;
      chk_cnt++; if (alu_res_WB !== 32'd0 || write_register_WB !== 5'd0 || wb_WB !== 2'b00 || read_data_WB !== 32'd0)
         $display("FAIL rb_wb got %h/%0d/%b/%h exp all 0", alu_res_WB, write_register_WB, wb_WB, read_data_WB); else pass_cnt++;
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_misaligned();
      m_MEM = 3'b010; res = 32'h44; wb_MEM = 2'b11; dmem_ack = 1'b1; dmem_rdata = 32'h11112222;
      tick();
      m_MEM = 3'b010; res = 32'h42; wb_MEM = 2'b11; write_register = 5'd6;
`ifdef MEM_ALIGN_CHECK_EN
      dmem_ack = 1'b0;
      #1;
      chk_cnt++; if (dmem_req !== 1'b0 || stall !== 1'b0)
         $display("FAIL mis_req got req=%b stall=%b exp 0/0", dmem_req, stall); else pass_cnt++;
      tick();
      drive_idle();
      chk_cnt++; if (bus_err !== 1'b1 || wb_WB !== 2'b00)
         $display("FAIL mis_err got bus_err=%b wb=%b exp 1/00", bus_err, wb_WB); else pass_cnt++;
`else
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      #1;
      chk_cnt++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h42)
         $display("FAIL mis_req got req=%b addr=%h exp 1/42", dmem_req, dmem_addr); else pass_cnt++;
      tick();
      drive_idle();
      chk_cnt++; if (bus_err !== 1'b0 || read_data_WB !== 32'hCAFEF00D || wb_WB !== 2'b11)
         $display("FAIL mis_ld got bus_err=%b rdata=%h wb=%b exp 0/cafef00d/11", bus_err, read_data_WB, wb_WB); else pass_cnt++;
`endif
      tick();
      chk_cnt++; if (bus_err !== 1'b0) $display("FAIL mis_pulse got %b exp 0", bus_err); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_zero_wait_load();
      test_wait_store();
      test_timeout();
      test_branch();
      test_reset_mid_busy();
      test_misaligned();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
